// File: rtl/rf_spi_slave_regfile.sv
// rf_spi_slave_regfile
//   SPI mode-0 responder emulating an ADF4351-style 32-bit write register file.
//   SCK/CS/SDI are oversampled with sys_clk. Each MSB-first 32-bit frame is
//   committed to the register selected by frame bits [2:0]. During the same
//   frame the register written by the previous good frame is shifted out on SDO.
// Ports
//   sys_clk       system clock, at least 8x the SCK frequency
//   sys_rest      synchronous reset, active-low
//   spi_sck       SPI clock, mode 0 (asynchronous)
//   spi_cs        chip select, active-low (asynchronous)
//   spi_sdi       master-to-slave data (asynchronous)
//   spi_sdo       slave-to-master data, registered
//   spi_sdo_oe    high while the synchronized CS is low during a frame
//   reg_wr_valid  one-cycle pulse on a committed write
//   reg_wr_addr   address of the committed write
//   reg_wr_data   full frame of the committed write
//   reg_file      all registers, reg N at [32N+31:32N]
//   frame_err     one-cycle pulse when CS rises with a bit count other than FRAME_BITS
//   addr_err      one-cycle pulse for a full frame whose address is out of range
//   frame_cnt     count of committed good writes, wrapping
module rf_spi_slave_regfile #(
  parameter int NUM_REGS   = 6,
  parameter int FRAME_BITS = 32,
  parameter int CNT_W      = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_rest,
  input  logic                     spi_sck,
  input  logic                     spi_cs,
  input  logic                     spi_sdi,
  output logic                     spi_sdo,
  output logic                     spi_sdo_oe,
  output logic                     reg_wr_valid,
  output logic [2:0]               reg_wr_addr,
  output logic [31:0]              reg_wr_data,
  output logic [32*NUM_REGS-1:0]   reg_file,
  output logic                     frame_err,
  output logic                     addr_err,
  output logic [CNT_W-1:0]         frame_cnt
);

  localparam int              BC_W    = $clog2(FRAME_BITS + 2);
  localparam logic [BC_W-1:0] BC_FULL = BC_W'(FRAME_BITS);
  localparam logic [BC_W-1:0] BC_SAT  = BC_W'(FRAME_BITS + 1);
  localparam logic [3:0]      NREG_C  = 4'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, ABORT} state_t;

  state_t state_q, state_d;

  logic sck_m_q, sck_s_q, sck_h_q;
  logic cs_m_q, cs_s_q, cs_h_q;
  logic sdi_m_q, sdi_s_q;
  logic [1:0] fill_q, fill_d;
  logic armed_q, armed_d;

  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0]      rx_sr_q, rx_sr_d;
  logic [31:0]      tx_sr_q, tx_sr_d;
  logic [2:0]       last_addr_q, last_addr_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             sdo_q, sdo_d;
  logic             oe_q, oe_d;
  logic [31:0]      reg_q [NUM_REGS];
  logic [31:0]      reg_d [NUM_REGS];

  logic        sck_rise, sck_fall, cs_fall, cs_rise;
  logic        addr_ok;
  logic [31:0] rd_word;

  // Input synchronizers: 2 FFs per pin plus a history FF for SCK/CS edges.
  always_ff @(posedge sys_clk) begin
    if (!sys_rest) begin
      sck_m_q <= 1'b0;
      sck_s_q <= 1'b0;
      sck_h_q <= 1'b0;
      cs_m_q  <= 1'b1;
      cs_s_q  <= 1'b1;
      cs_h_q  <= 1'b1;
      sdi_m_q <= 1'b0;
      sdi_s_q <= 1'b0;
      fill_q  <= 2'd0;
      armed_q <= 1'b0;
    end else begin
      sck_m_q <= spi_sck;
      sck_s_q <= sck_m_q;
      sck_h_q <= sck_s_q;
      cs_m_q  <= spi_cs;
      cs_s_q  <= cs_m_q;
      cs_h_q  <= cs_s_q;
      sdi_m_q <= spi_sdi;
      sdi_s_q <= sdi_m_q;
      fill_q  <= fill_d;
      armed_q <= armed_d;
    end
  end

  // The synchronizer comes out of reset holding CS=1, so a pin already low at
  // release would look like a falling edge. Frames are only accepted once CS
  // has been seen high through a fully refilled synchronizer.
  always_comb begin
    fill_d  = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
    armed_d = armed_q | ((fill_q == 2'd3) & cs_s_q);
  end

  assign sck_rise = sck_s_q & ~sck_h_q;
  assign sck_fall = ~sck_s_q & sck_h_q;
  assign cs_fall  = cs_h_q & ~cs_s_q & armed_q;
  assign cs_rise  = ~cs_h_q & cs_s_q;

  assign addr_ok  = ({1'b0, rx_sr_q[2:0]} < NREG_C);

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (last_addr_q == 3'(i)) rd_word = reg_q[i];
    end
  end

  // FSM state register
  always_ff @(posedge sys_clk) begin
    if (!sys_rest) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT:   if (cs_rise) state_d = (bit_cnt_q == BC_FULL) ? COMMIT : ABORT;
      COMMIT:  state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    reg_wr_valid = (state_q == COMMIT) & addr_ok;
    addr_err     = (state_q == COMMIT) & ~addr_ok;
    frame_err    = (state_q == ABORT);
    reg_wr_addr  = reg_wr_valid ? rx_sr_q[2:0] : 3'd0;
    reg_wr_data  = reg_wr_valid ? rx_sr_q : 32'd0;
  end

  // Datapath next state. A CS rise in the same cycle as an SCK edge discards the SCK edge.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    last_addr_d = last_addr_q;
    frame_cnt_d = frame_cnt_q;
    for (int i = 0; i < NUM_REGS; i++) reg_d[i] = reg_q[i];
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          bit_cnt_d = '0;
          tx_sr_d   = rd_word;
        end
      end
      SHIFT: begin
        if (!cs_rise) begin
          if (sck_rise) begin
            rx_sr_d = {rx_sr_q[30:0], sdi_s_q};
            if (bit_cnt_q != BC_SAT) bit_cnt_d = bit_cnt_q + 1'b1;
          end
          if (sck_fall) tx_sr_d = {tx_sr_q[30:0], 1'b0};
        end
      end
      COMMIT: begin
        if (addr_ok) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (rx_sr_q[2:0] == 3'(i)) reg_d[i] = rx_sr_q;
          end
          frame_cnt_d = frame_cnt_q + 1'b1;
          last_addr_d = rx_sr_q[2:0];
        end
      end
      default: ;
    endcase
    sdo_d = (state_q == SHIFT) & tx_sr_q[31];
    oe_d  = armed_q & ~cs_s_q;
  end

  // Datapath registers
  always_ff @(posedge sys_clk) begin
    if (!sys_rest) begin
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      last_addr_q <= '0;
      frame_cnt_q <= '0;
      sdo_q       <= 1'b0;
      oe_q        <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= '0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      last_addr_q <= last_addr_d;
      frame_cnt_q <= frame_cnt_d;
      sdo_q       <= sdo_d;
      oe_q        <= oe_d;
      for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= reg_d[i];
    end
  end

  always_comb begin
    reg_file = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_file[32*i +: 32] = reg_q[i];
  end

  assign spi_sdo    = sdo_q;
  assign spi_sdo_oe = oe_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_rf_spi_slave_regfile.sv
// Testbench for rf_spi_slave_regfile: table of directed frames, reset-mid-frame
// sequence, randomized frames against a behavioural register-file model, and a
// counter wrap check on a second instance with a narrow frame counter.
module tb_rf_spi_slave_regfile;

  localparam int HALF = 8;
  localparam int NR   = 6;

  logic sys_clk = 1'b0;
  logic sys_rest, spi_sck, spi_cs, spi_sdi;

  logic          spi_sdo, spi_sdo_oe, reg_wr_valid, frame_err, addr_err;
  logic [2:0]    reg_wr_addr;
  logic [31:0]   reg_wr_data;
  logic [32*NR-1:0] reg_file;
  logic [15:0]   frame_cnt;

  logic          sdo_b, oe_b, wr_valid_b, ferr_b, aerr_b;
  logic [2:0]    wr_addr_b;
  logic [31:0]   wr_data_b;
  logic [32*NR-1:0] reg_file_b;
  logic [3:0]    frame_cnt_b;

  always #5 sys_clk = ~sys_clk;

  rf_spi_slave_regfile #(.NUM_REGS(NR), .FRAME_BITS(32), .CNT_W(16)) dut (
    .sys_clk(sys_clk), .sys_rest(sys_rest), .spi_sck(spi_sck), .spi_cs(spi_cs),
    .spi_sdi(spi_sdi), .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe),
    .reg_wr_valid(reg_wr_valid), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .reg_file(reg_file), .frame_err(frame_err), .addr_err(addr_err), .frame_cnt(frame_cnt)
  );

  rf_spi_slave_regfile #(.NUM_REGS(NR), .FRAME_BITS(32), .CNT_W(4)) dut_b (
    .sys_clk(sys_clk), .sys_rest(sys_rest), .spi_sck(spi_sck), .spi_cs(spi_cs),
    .spi_sdi(spi_sdi), .spi_sdo(sdo_b), .spi_sdo_oe(oe_b),
    .reg_wr_valid(wr_valid_b), .reg_wr_addr(wr_addr_b), .reg_wr_data(wr_data_b),
    .reg_file(reg_file_b), .frame_err(ferr_b), .addr_err(aerr_b), .frame_cnt(frame_cnt_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  // pulse monitor: counts high cycles, so a stretched pulse shows as >1
  int          wr_cnt = 0, aerr_cnt = 0, ferr_cnt = 0;
  logic [2:0]  mon_addr = '0;
  logic [31:0] mon_data = '0;
  always @(negedge sys_clk) begin
    if (reg_wr_valid) begin
      wr_cnt++;
      mon_addr = reg_wr_addr;
      mon_data = reg_wr_data;
    end
    if (addr_err)  aerr_cnt++;
    if (frame_err) ferr_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // behavioural model of the register file
  logic [31:0] m_regs [NR];
  logic [2:0]  m_last;
  int          m_cnt;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_last = '0;
    m_cnt  = 0;
  endtask

  task automatic model_frame(input logic [63:0] d, input int n,
                             output bit ew, output bit ea, output bit ef,
                             output logic [63:0] emiso);
    logic [63:0] rb;
    rb = {32'd0, m_regs[m_last]};
    emiso = (n <= 32) ? (rb >> (32 - n)) : (rb << (n - 32));
    ew = 0; ea = 0; ef = 0;
    if (n != 32)            ef = 1;
    else if (d[2:0] >= NR)  ea = 1;
    else begin
      ew = 1;
      m_regs[d[2:0]] = d[31:0];
      m_last = d[2:0];
      m_cnt++;
    end
  endtask

  logic [63:0] miso_acc;

  task automatic spi_bits(input logic [63:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_sdi = d[i];
      repeat (HALF) @(negedge sys_clk);
      miso_acc = {miso_acc[62:0], spi_sdo};
      spi_sck = 1'b1;
      repeat (HALF) @(negedge sys_clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [63:0] d, input int n,
                           output int dwr, output int da, output int df,
                           output logic [63:0] miso, output logic oe_mid);
    int w0, a0, f0;
    w0 = wr_cnt; a0 = aerr_cnt; f0 = ferr_cnt;
    miso_acc = '0;
    spi_cs = 1'b0;
    repeat (HALF) @(negedge sys_clk);
    oe_mid = spi_sdo_oe;
    spi_bits(d, n);
    repeat (HALF) @(negedge sys_clk);
    spi_cs = 1'b1;
    repeat (2 * HALF) @(negedge sys_clk);
    dwr = wr_cnt - w0; da = aerr_cnt - a0; df = ferr_cnt - f0;
    miso = miso_acc;
  endtask

  task automatic frame_vs_model(input logic [63:0] d, input int n);
    int dwr, da, df;
    logic [63:0] miso, emiso;
    logic oe_mid;
    bit ew, ea, ef;
    model_frame(d, n, ew, ea, ef, emiso);
    run_frame(d, n, dwr, da, df, miso, oe_mid);
    check("rnd_wr",   64'(dwr), 64'(ew));
    check("rnd_aerr", 64'(da),  64'(ea));
    check("rnd_ferr", 64'(df),  64'(ef));
    check("rnd_miso", miso, emiso);
    check("rnd_cnt",  64'(frame_cnt), 64'(m_cnt[15:0]));
    check("rnd_cnt4", 64'(frame_cnt_b), 64'(m_cnt[3:0]));
    if (ew) begin
      check("rnd_addr", 64'(mon_addr), 64'(d[2:0]));
      check("rnd_data", 64'(mon_data), 64'(d[31:0]));
    end
  endtask

  typedef struct {
    logic [63:0] data;
    int          nbits;
    bit          exp_wr;
    bit          exp_aerr;
    bit          exp_ferr;
    logic [63:0] exp_miso;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int dwr, da, df;
    logic [63:0] miso, emiso_unused;
    logic oe_mid;
    bit ew, ea, ef;
    logic [63:0] d;
    int n;

    vecs[0] = '{64'h0000_0000_0058_0005, 32, 1'b1, 1'b0, 1'b0, 64'h0000_0000_0000_0000, 16'd1};
    vecs[1] = '{64'h0000_0000_1234_5671, 32, 1'b1, 1'b0, 1'b0, 64'h0000_0000_0058_0005, 16'd2};
    vecs[2] = '{64'h0000_0000_A5A5_A5A0, 32, 1'b1, 1'b0, 1'b0, 64'h0000_0000_1234_5671, 16'd3};
    vecs[3] = '{64'h0000_0000_7FFF_FFFF, 31, 1'b0, 1'b0, 1'b1, 64'h0000_0000_52D2_D2D0, 16'd3};
    vecs[4] = '{64'h0000_0001_2345_6780, 33, 1'b0, 1'b0, 1'b1, 64'h0000_0001_4B4B_4B40, 16'd3};
    vecs[5] = '{64'h0000_0000_FFFF_FFF6, 32, 1'b0, 1'b1, 1'b0, 64'h0000_0000_A5A5_A5A0, 16'd3};
    vecs[6] = '{64'h0000_0000_FFFF_FFF7, 32, 1'b0, 1'b1, 1'b0, 64'h0000_0000_A5A5_A5A0, 16'd3};
    vecs[7] = '{64'h0000_0000_0000_BEE2, 32, 1'b1, 1'b0, 1'b0, 64'h0000_0000_A5A5_A5A0, 16'd4};
    vecs[8] = '{64'h0000_0000_CAFE_0003, 32, 1'b1, 1'b0, 1'b0, 64'h0000_0000_0000_BEE2, 16'd5};

    sys_rest = 1'b0; spi_cs = 1'b1; spi_sck = 1'b0; spi_sdi = 1'b0;
    model_reset();
    repeat (5) @(negedge sys_clk);
    check("rst_reg_file", 64'(reg_file != '0), 64'd0);
    check("rst_cnt",  64'(frame_cnt), 64'd0);
    check("rst_outs", {58'd0, spi_sdo, spi_sdo_oe, reg_wr_valid, frame_err, addr_err, |reg_wr_data}, 64'd0);
    sys_rest = 1'b1;
    repeat (10) @(negedge sys_clk);

    // directed table
    for (int v = 0; v < 9; v++) begin
      model_frame(vecs[v].data, vecs[v].nbits, ew, ea, ef, emiso_unused);
      run_frame(vecs[v].data, vecs[v].nbits, dwr, da, df, miso, oe_mid);
      check($sformatf("v%0d_wr", v),   64'(dwr), 64'(vecs[v].exp_wr));
      check($sformatf("v%0d_aerr", v), 64'(da),  64'(vecs[v].exp_aerr));
      check($sformatf("v%0d_ferr", v), 64'(df),  64'(vecs[v].exp_ferr));
      check($sformatf("v%0d_miso", v), miso, vecs[v].exp_miso);
      check($sformatf("v%0d_cnt", v),  64'(frame_cnt), 64'(vecs[v].exp_cnt));
      check($sformatf("v%0d_oe", v),   64'(oe_mid), 64'd1);
      if (vecs[v].exp_wr) begin
        check($sformatf("v%0d_addr", v), 64'(mon_addr), 64'(vecs[v].data[2:0]));
        check($sformatf("v%0d_data", v), 64'(mon_data), 64'(vecs[v].data[31:0]));
      end
    end
    check("oe_idle", 64'(spi_sdo_oe), 64'd0);
    check("reg0", 64'(reg_file[0*32 +: 32]), 64'h A5A5_A5A0);
    check("reg1", 64'(reg_file[1*32 +: 32]), 64'h 1234_5671);
    check("reg2", 64'(reg_file[2*32 +: 32]), 64'h 0000_BEE2);
    check("reg3", 64'(reg_file[3*32 +: 32]), 64'h CAFE_0003);
    check("reg4", 64'(reg_file[4*32 +: 32]), 64'h 0000_0000);
    check("reg5", 64'(reg_file[5*32 +: 32]), 64'h 0058_0005);

    // reset at bit 16 of a frame, released with CS still low
    begin
      int w0, a0, f0;
      w0 = wr_cnt; a0 = aerr_cnt; f0 = ferr_cnt;
      miso_acc = '0;
      spi_cs = 1'b0;
      repeat (HALF) @(negedge sys_clk);
      spi_bits(64'h0000_0000_0000_DEAD, 16);
      sys_rest = 1'b0;
      repeat (4) @(negedge sys_clk);
      sys_rest = 1'b1;
      spi_bits(64'h0000_0000_0000_0002, 16);
      repeat (HALF) @(negedge sys_clk);
      check("rstmid_oe", 64'(spi_sdo_oe), 64'd0);
      spi_cs = 1'b1;
      repeat (2 * HALF) @(negedge sys_clk);
      check("rstmid_pulses", 64'((wr_cnt - w0) + (aerr_cnt - a0) + (ferr_cnt - f0)), 64'd0);
      check("rstmid_regs", 64'(reg_file != '0), 64'd0);
      check("rstmid_cnt", 64'(frame_cnt), 64'd0);
      model_reset();
    end
    frame_vs_model(64'h0000_0000_0000_0104, 32);
    check("post_rst_reg4", 64'(reg_file[4*32 +: 32]), 64'h0000_0104);

    // randomized frames against the model
    for (int k = 0; k < 40; k++) begin
      d = {$urandom, $urandom};
      n = ($urandom_range(0, 9) < 8) ? 32 : int'($urandom_range(28, 36));
      frame_vs_model(d, n);
    end
    for (int i = 0; i < NR; i++)
      check($sformatf("rnd_reg%0d", i), 64'(reg_file[32*i +: 32]), 64'(m_regs[i]));

    // counter wrap on the narrow-counter instance
    while ((m_cnt % 16) != 15) begin
      d = {32'd0, $urandom_range(0, 32'hFFFF) << 3} | 64'($urandom_range(0, NR - 1));
      frame_vs_model(d, 32);
    end
    check("wrap_pre", 64'(frame_cnt_b), 64'hF);
    frame_vs_model(64'h0000_0000_5555_AAA2, 32);
    check("wrap_post", 64'(frame_cnt_b), 64'h0);
    check("wrap_wide", 64'(frame_cnt), 64'(m_cnt[15:0]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
